barrier_controller: RTL and testbench
=====================================

// Module: barrier_controller
// PURPOSE
//  Game-side initiator for one barrier lane: schedules barrier spawns, drives the barrier's
//  active input, waits for its in_position flag, then judges dodge vs collision from
//  pixel-level hit overlap with the player sprite. Keeps lives and game-over state.
//  Sits between the barrier sprite and the top-level game FSM / HUD.
// PARAMETERS
//  SPAWN_MIN_FRAMES  30  minimum idle frames before the next spawn
//  SPAWN_RAND_BITS   5   LFSR bits added to the idle delay (0..2^N-1 extra frames)
//  CHECK_FRAMES      4   frames in the collision window after in_position is seen
//  APPROACH_TIMEOUT  64  frames in APPROACH with no in_position before abort
//  RETIRE_FRAMES     2   frames active is held low so the barrier returns to its start
//  LIVES_INIT        3   lives loaded on reset/start (1..15)
// PORTS
//  i_clk          in   1   pixel clock
//  i_rst          in   1   synchronous, active-high reset
//  i_start        in   1   one-cycle pulse: start/restart game
//  i_v_sync       in   1   vertical sync level (async; synchronised internally)
//  i_in_position  in   1   barrier in_position (v_sync domain; synchronised internally)
//  i_barrier_hit  in   1   barrier o_sprite_hit for current pixel
//  i_player_hit   in   1   player sprite hit for current pixel
//  o_active       out  1   barrier active drive
//  o_collision    out  1   one-cycle pulse: player hit the barrier
//  o_dodge        out  1   one-cycle pulse: barrier passed without contact
//  o_lives        out  4   remaining lives
//  o_game_over    out  1   high while lives==0 and not restarted
//  o_state        out  3   FSM state encoding (debug)
// BEHAVIOUR
//  - i_v_sync, i_in_position: 2-flop synchronisers; frame_tick = 1-cycle pulse on synced
//    v_sync rising edge. All frame counters advance on frame_tick only.
//  - Reset values: o_active=0, o_collision=0, o_dodge=0, o_lives=LIVES_INIT, o_game_over=0,
//    state=STOPPED(0), LFSR=8'hA5 (8-bit, taps 8,6,5,4, never all-zero).
//  - States: STOPPED=0, IDLE=1, APPROACH=2, CHECK=3, RESOLVE=4, RETIRE=5.
//  - STOPPED: o_active=0; i_start -> IDLE, lives:=LIVES_INIT, game_over:=0.
//  - IDLE: on entry load delay = SPAWN_MIN_FRAMES + LFSR[SPAWN_RAND_BITS-1:0]; LFSR steps each
//    frame_tick; delay reaches 0 on frame_tick -> APPROACH.
//  - APPROACH: o_active=1 (registered, asserted the cycle after entry). Synced in_position==1
//    any cycle -> CHECK (in_position is one frame wide; level-sampled every cycle, not on tick).
//    APPROACH_TIMEOUT frame_ticks without it -> RETIRE, no pulse, no life lost.
//  - CHECK: o_active=1; hit_flag set any cycle with i_barrier_hit&&i_player_hit. Window ends
//    after CHECK_FRAMES frame_ticks -> RESOLVE.
//  - RESOLVE (1 cycle): hit_flag=1 -> o_collision pulse, lives-1 (saturate at 0);
//    else o_dodge pulse. Exactly one pulse per spawn. Then RETIRE; hit_flag cleared.
//  - RETIRE: o_active=0 for RETIRE_FRAMES frame_ticks; then lives==0 -> STOPPED with
//    o_game_over=1, else IDLE.
//  - Simultaneous: i_rst dominates everything. i_start in any non-STOPPED state restarts:
//    o_active=0 next cycle, lives reloaded, counters/hit_flag cleared, -> IDLE.
//    Hit overlap in the same cycle as RESOLVE is ignored (window closed).
//  - o_game_over cleared only by i_start or i_rst. Pulses never coincide.
// CONFIGURATION
//  BARRIER_CTRL_SCORE_EN defined: adds port o_score out 16; reset/start -> 0; +1 per o_dodge,
//    saturating at 16'd9999; collisions do not change it.
//  Undefined: no o_score port, no score logic; all other behaviour identical.
// TESTING
//  1 Reset, i_start, SPAWN_RAND_BITS forced 0 -> o_active rises after exactly 30 frame_ticks(+sync lat).
//  2 Spawn, pulse in_position 1 frame, no player overlap 4 frames -> one o_dodge, lives stays 3.
//  3 Spawn, in_position, one cycle barrier_hit&player_hit in window -> one o_collision, lives 3->2.
//  4 Three collisions in a row -> lives 0, o_active low, o_game_over=1, state STOPPED; i_start clears.
//  5 Spawn with in_position never asserted -> after 64 frames RETIRE, o_active low 2 frames, no pulse.
//  6 i_start mid-CHECK with overlap pending -> no pulse, o_active 0 next cycle, lives=3, state IDLE;
//    with BARRIER_CTRL_SCORE_EN, 10 dodges -> o_score=10, restart -> 0.

Source files
------------

// File: rtl/barrier_controller.sv
// barrier_controller: game-side initiator for one barrier lane. Schedules spawns, drives the
// barrier active input, waits for in_position, judges dodge vs collision from pixel overlap,
// and keeps lives / game-over state.
// Optional build macro: BARRIER_CTRL_SCORE_EN adds o_score (saturating dodge counter).
module barrier_controller #(
  parameter int unsigned SPAWN_MIN_FRAMES = 30,
  parameter int unsigned SPAWN_RAND_BITS  = 5,
  parameter int unsigned CHECK_FRAMES     = 4,
  parameter int unsigned APPROACH_TIMEOUT = 64,
  parameter int unsigned RETIRE_FRAMES    = 2,
  parameter int unsigned LIVES_INIT       = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_v_sync,
  input  logic        i_in_position,
  input  logic        i_barrier_hit,
  input  logic        i_player_hit,
  output logic        o_active,
  output logic        o_collision,
  output logic        o_dodge,
  output logic [3:0]  o_lives,
  output logic        o_game_over,
`ifdef BARRIER_CTRL_SCORE_EN
  output logic [15:0] o_score,
`endif
  output logic [2:0]  o_state
);

  localparam int unsigned CntW     = 8;
  localparam logic [7:0]  RandMask = 8'((1 << SPAWN_RAND_BITS) - 1);

  typedef enum logic [2:0] {
    StStopped  = 3'd0,
    StIdle     = 3'd1,
    StApproach = 3'd2,
    StCheck    = 3'd3,
    StResolve  = 3'd4,
    StRetire   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        vs_sync_q;
  logic [1:0]        ip_sync_q;
  logic              frame_tick, in_pos_sync;
  logic [CntW-1:0]   cnt_q, cnt_d, delay_q, delay_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              hit_q, hit_d;
  logic [3:0]        lives_q, lives_d;
  logic              game_over_q, game_over_d;
  logic              active_q, active_d;
  logic              collision_q, collision_d;
  logic              dodge_q, dodge_d;

  assign frame_tick  = vs_sync_q[1] & ~vs_sync_q[2];
  assign in_pos_sync = ip_sync_q[1];

  // Two-flop synchronisers; the third v_sync flop gives the rising-edge detect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_sync_q <= '0;
      ip_sync_q <= '0;
    end else begin
      vs_sync_q <= {vs_sync_q[1:0], i_v_sync};
      ip_sync_q <= {ip_sync_q[0], i_in_position};
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StStopped;
    else       state_q <= state_d;
  end

  // FSM next-state; start restarts from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStopped:  if (i_start) state_d = StIdle;
      StIdle:     if (frame_tick && (cnt_q == delay_q - CntW'(1))) state_d = StApproach;
      StApproach: begin
        // in_position is level-sampled every cycle since it lasts only one frame
        if (in_pos_sync) state_d = StCheck;
        else if (frame_tick && (cnt_q == CntW'(APPROACH_TIMEOUT - 1))) state_d = StRetire;
      end
      StCheck:    if (frame_tick && (cnt_q == CntW'(CHECK_FRAMES - 1))) state_d = StResolve;
      StResolve:  state_d = StRetire;
      StRetire: begin
        if (frame_tick && (cnt_q == CntW'(RETIRE_FRAMES - 1))) begin
          state_d = (lives_q == 4'd0) ? StStopped : StIdle;
        end
      end
      default:    state_d = StStopped;
    endcase
    if (i_start) state_d = StIdle;
  end

  // Outputs and datapath next values (registered below)
  always_comb begin
    active_d    = (state_d == StApproach) || (state_d == StCheck);
    collision_d = (state_q == StResolve) && hit_q && !i_start;
    dodge_d     = (state_q == StResolve) && !hit_q && !i_start;

    lives_d = lives_q;
    if (i_start) lives_d = 4'(LIVES_INIT);
    else if (collision_d && (lives_q != 4'd0)) lives_d = lives_q - 4'd1;

    game_over_d = game_over_q;
    if (i_start) game_over_d = 1'b0;
    else if ((state_q == StRetire) && (state_d == StStopped)) game_over_d = 1'b1;

    // Overlap only counts while the window is open; RESOLVE consumes and clears it
    hit_d = 1'b0;
    if (!i_start && (state_q == StCheck)) hit_d = hit_q | (i_barrier_hit & i_player_hit);

    cnt_d = cnt_q;
    if (i_start || (state_d != state_q)) cnt_d = '0;
    else if (frame_tick) cnt_d = cnt_q + CntW'(1);

    delay_d = delay_q;
    if ((state_d == StIdle) && (i_start || (state_q != StIdle))) begin
      delay_d = CntW'(SPAWN_MIN_FRAMES) + CntW'(lfsr_q & RandMask);
    end

    // Fibonacci LFSR, taps 8,6,5,4
    lfsr_d = lfsr_q;
    if ((state_q == StIdle) && frame_tick && !i_start) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q       <= '0;
      delay_q     <= '0;
      lfsr_q      <= 8'hA5;
      hit_q       <= 1'b0;
      lives_q     <= 4'(LIVES_INIT);
      game_over_q <= 1'b0;
      active_q    <= 1'b0;
      collision_q <= 1'b0;
      dodge_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      lfsr_q      <= lfsr_d;
      hit_q       <= hit_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      active_q    <= active_d;
      collision_q <= collision_d;
      dodge_q     <= dodge_d;
    end
  end

`ifdef BARRIER_CTRL_SCORE_EN
  logic [15:0] score_q;

  // Dodge score, cleared on start, saturating at 9999
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) score_q <= '0;
    else if (dodge_d && (score_q != 16'd9999)) score_q <= score_q + 16'd1;
  end

  assign o_score = score_q;
`endif

  assign o_active    = active_q;
  assign o_collision = collision_q;
  assign o_dodge     = dodge_q;
  assign o_lives     = lives_q;
  assign o_game_over = game_over_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_barrier_controller.sv
// Scoreboard bench for barrier_controller: frame-level reference model (tick arithmetic, LFSR,
// lives) with a decoupled pulse monitor.
`timescale 1ns/1ps
module tb_barrier_controller;

  localparam int Frame     = 16;
  localparam int VsHigh    = 4;
  localparam int LivesInit = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, v_sync = 1'b1, in_pos = 1'b0, b_hit = 1'b0, p_hit = 1'b0;
  logic       active, collision, dodge, game_over;
  logic [3:0] lives;
  logic [2:0] state;
`ifdef BARRIER_CTRL_SCORE_EN
  logic [15:0] score;
`endif

  barrier_controller dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_v_sync      (v_sync),
    .i_in_position (in_pos),
    .i_barrier_hit (b_hit),
    .i_player_hit  (p_hit),
    .o_active      (active),
    .o_collision   (collision),
    .o_dodge       (dodge),
    .o_lives       (lives),
    .o_game_over   (game_over),
`ifdef BARRIER_CTRL_SCORE_EN
    .o_score       (score),
`endif
    .o_state       (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int vs_rises = 0;

  typedef struct {
    bit col;
    int lives;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_lfsr;
  int m_lives;
  int m_score;
  int t_entry;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_mid();
    int n = 0;
    do begin
      step();
      n++;
    end while (phase != 8 && n < 2 * Frame);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic overlap(input bit b, input bit p);
    b_hit = b;
    p_hit = p;
    step();
    b_hit = 1'b0;
    p_hit = 1'b0;
  endtask

  task automatic wait_active(input logic lvl, input int budget, input string name);
    int n = 0;
    while (active !== lvl && n < budget) begin
      step();
      n++;
    end
    if (active !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: o_active got %0b expected %0b within %0d cycles", name, active, lvl, budget);
    end
  endtask

  // Idle delay from the current LFSR, then advance the LFSR once per idle frame
  task automatic spawn_delay(output int d);
    d = 30 + (int'(m_lfsr) % 32);
    for (int i = 0; i < d; i++) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic do_start();
    goto_mid();
    pulse_start();
    t_entry = vs_rises;
    m_lives = LivesInit;
    m_score = 0;
    check("start_lives", lives, LivesInit);
    check("start_game_over", game_over, 0);
    check("start_state", state, 1);
    check("start_active", active, 0);
  endtask

  task automatic leave_retire(input int exp_tick);
    int n = 0;
    bit low = 1'b1;
    while (state != 3'd0 && state != 3'd1 && n < 4 * Frame) begin
      step();
      n++;
      if (state == 3'd5 && active) low = 1'b0;
    end
    check("retire_low", low, 1);
    check("retire_tick", vs_rises, exp_tick);
    t_entry = exp_tick;
    if (m_lives == 0) begin
      check("over_state", state, 0);
      check("over_flag", game_over, 1);
      check("over_lives", lives, 0);
      repeat (3) goto_mid();
      check("over_hold_state", state, 0);
      check("over_hold_active", active, 0);
      do_start();
    end else begin
      check("idle_state", state, 1);
      check("idle_game_over", game_over, 0);
    end
`ifdef BARRIER_CTRL_SCORE_EN
    check("score", score, m_score);
`endif
  endtask

  // kind: 0 dodge, 1 collision, 2 approach timeout, 3 restart inside the window
  task automatic run_spawn(input int kind);
    int d, exp_rise, t_a, t_c;
    spawn_delay(d);
    exp_rise = t_entry + d;
    wait_active(1'b1, 70 * Frame, "spawn_wait");
    check("spawn_tick", vs_rises, exp_rise);
    check("approach_state", state, 2);
    t_a = vs_rises;
    if (kind == 2) begin
      wait_active(1'b0, 70 * Frame, "timeout_wait");
      check("timeout_tick", vs_rises, t_a + 64);
      check("timeout_state", state, 5);
      leave_retire(t_a + 66);
      return;
    end
    repeat ($urandom_range(0, 4)) goto_mid();
    if ($urandom_range(0, 1) == 1) overlap(1'b1, 1'b1);  // before the window: ignored
    goto_mid();
    in_pos = 1'b1;
    t_c = vs_rises;
    repeat (Frame) step();
    in_pos = 1'b0;
    check("check_state", state, 3);
    check("check_active", active, 1);
    if (kind == 3) begin
      overlap(1'b1, 1'b1);
      repeat ($urandom_range(1, 4)) step();
      pulse_start();
      t_entry = vs_rises;
      m_lives = LivesInit;
      m_score = 0;
      check("restart_active", active, 0);
      check("restart_lives", lives, LivesInit);
      check("restart_state", state, 1);
      return;
    end
    repeat ($urandom_range(0, 2)) goto_mid();
    if (kind == 1) begin
      overlap(1'b1, 1'b1);
      if (m_lives > 0) m_lives--;
    end else begin
      overlap(1'b1, 1'b0);
      overlap(1'b0, 1'b1);
      if (m_score < 9999) m_score++;
    end
    exp_q.push_back('{col: (kind == 1), lives: m_lives});
    wait_active(1'b0, 6 * Frame, "window_wait");
    check("window_tick", vs_rises, t_c + 4);
    check("resolve_state", state, 4);
    leave_retire(t_c + 6);
  endtask

  // Frame generator: v_sync high for VsHigh of every Frame cycles
  initial forever begin
    @(posedge clk);
    #2;
    phase = (phase + 1) % Frame;
    v_sync = (phase < VsHigh);
    if (phase == 0) vs_rises++;
  end

  // Pulse monitor: pops one expectation per collision/dodge pulse
  initial begin
    exp_t e;
    forever begin
      step();
      if (!rst) begin
        if (collision && dodge) begin
          checks++;
          errors++;
          $display("FAIL pulse_overlap: got collision=1 dodge=1 expected at most one");
        end else if (collision || dodge) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got collision=%0b dodge=%0b expected none",
                     collision, dodge);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind", collision, e.col);
            check("pulse_lives", lives, e.lives);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    repeat (4) step();
    check("rst_active", active, 0);
    check("rst_collision", collision, 0);
    check("rst_dodge", dodge, 0);
    check("rst_lives", lives, LivesInit);
    check("rst_game_over", game_over, 0);
    check("rst_state", state, 0);
    goto_mid();
    rst = 1'b0;  // released while v_sync is low
    m_lfsr = 8'hA5;
    repeat (3) goto_mid();
    check("stopped_state", state, 0);
    check("stopped_active", active, 0);
    do_start();
    run_spawn(0);
    run_spawn(1);
    run_spawn(2);
    run_spawn(3);
    repeat (3) run_spawn(1);
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 9);
      run_spawn(r < 5 ? 0 : (r < 8 ? 1 : (r == 8 ? 2 : 3)));
    end
    repeat (4) step();
    check("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
